// File: rtl/memory_port_arbiter.sv
// Arbitrates the single data-memory port between the load unit and the store-buffer drain.
// Define MEM_PORT_TIMEOUT_EN to add a per-transaction timeout that reports bus_error_o.
module memory_port_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        ld_request_i,
    input  logic [31:0] ld_address_i,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    input  logic        st_request_i,
    input  logic [31:0] st_address_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  st_width_i,
    input  logic        st_buffer_full_i,
    output logic        st_done_o,
    output logic        mem_load_o,
    output logic        mem_store_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic [1:0]  mem_width_o,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_done_i,
    output logic        bus_error_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2
    } state_e;

    localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

    state_e          state_q, state_d;
    logic            ld_pending_q, ld_pending_d;
    logic [31:0]     ld_addr_q, ld_addr_d;
    logic            st_pending_q, st_pending_d;
    logic [31:0]     st_addr_q, st_addr_d;
    logic [31:0]     st_data_q, st_data_d;
    logic [1:0]      st_width_q, st_width_d;
    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;
    logic            squash_q, squash_d;
    logic            mem_load_q, mem_load_d;
    logic            mem_store_q, mem_store_d;
    logic [31:0]     mem_address_q, mem_address_d;
    logic [31:0]     mem_data_q, mem_data_d;
    logic [1:0]      mem_width_q, mem_width_d;

    logic grant_ld, grant_st;
    logic ld_resp, st_resp, timeout;
    logic ld_busy, st_busy, ld_capture, st_capture;
    logic starve_hit;

    assign ld_resp    = (state_q == LOAD_WAIT)  && mem_valid_i;
    assign st_resp    = (state_q == STORE_WAIT) && mem_done_i;
    assign starve_hit = (starve_cnt_q == SC_W'(STARVE_LIMIT));

    // A channel frees up in the very cycle its response (or timeout) arrives.
    assign ld_busy    = ld_pending_q || ((state_q == LOAD_WAIT)  && !mem_valid_i && !timeout);
    assign st_busy    = st_pending_q || ((state_q == STORE_WAIT) && !mem_done_i  && !timeout);
    assign ld_capture = ld_request_i && !ld_busy;
    assign st_capture = st_request_i && !st_busy;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (state_q == IDLE || state_d == IDLE) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign timeout = (state_q != IDLE) && !ld_resp && !st_resp &&
                     (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register and all datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            ld_pending_q  <= 1'b0;
            ld_addr_q     <= '0;
            st_pending_q  <= 1'b0;
            st_addr_q     <= '0;
            st_data_q     <= '0;
            st_width_q    <= '0;
            starve_cnt_q  <= '0;
            squash_q      <= 1'b0;
            mem_load_q    <= 1'b0;
            mem_store_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_width_q   <= '0;
        end else begin
            state_q       <= state_d;
            ld_pending_q  <= ld_pending_d;
            ld_addr_q     <= ld_addr_d;
            st_pending_q  <= st_pending_d;
            st_addr_q     <= st_addr_d;
            st_data_q     <= st_data_d;
            st_width_q    <= st_width_d;
            starve_cnt_q  <= starve_cnt_d;
            squash_q      <= squash_d;
            mem_load_q    <= mem_load_d;
            mem_store_q   <= mem_store_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_width_q   <= mem_width_d;
        end
    end

    // Next-state and grant selection; a flush blocks a load grant in the same cycle.
    always_comb begin
        state_d  = state_q;
        grant_ld = 1'b0;
        grant_st = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_pending_q && (st_buffer_full_i || starve_hit)) begin
                    grant_st = 1'b1;
                end else if (ld_pending_q && !flush_i) begin
                    grant_ld = 1'b1;
                end else if (st_pending_q) begin
                    grant_st = 1'b1;
                end
                if (grant_ld) begin
                    state_d = LOAD_WAIT;
                end else if (grant_st) begin
                    state_d = STORE_WAIT;
                end
            end
            LOAD_WAIT: begin
                if (mem_valid_i || timeout) begin
                    state_d = IDLE;
                end
            end
            STORE_WAIT: begin
                if (mem_done_i || timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ld_pending_d  = ld_pending_q;
        ld_addr_d     = ld_addr_q;
        st_pending_d  = st_pending_q;
        st_addr_d     = st_addr_q;
        st_data_d     = st_data_q;
        st_width_d    = st_width_q;
        starve_cnt_d  = starve_cnt_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_width_d   = mem_width_q;
        mem_load_d    = grant_ld;
        mem_store_d   = grant_st;

        if (grant_ld) begin
            ld_pending_d = 1'b0;
        end
        if (flush_i) begin
            ld_pending_d = 1'b0;
        end else if (ld_capture) begin
            ld_pending_d = 1'b1;
            ld_addr_d    = ld_address_i;
        end

        if (grant_st) begin
            st_pending_d = 1'b0;
        end
        if (st_capture) begin
            st_pending_d = 1'b1;
            st_addr_d    = st_address_i;
            st_data_d    = st_data_i;
            st_width_d   = st_width_i;
        end

        if (grant_ld) begin
            mem_address_d = ld_addr_q;
        end
        if (grant_st) begin
            mem_address_d = st_addr_q;
            mem_data_d    = st_data_q;
            mem_width_d   = st_width_q;
        end

        if (grant_st) begin
            starve_cnt_d = '0;
        end else if (grant_ld && st_pending_q && !starve_hit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        // The squash flag only lives while the flushed load is still outstanding.
        squash_d = 1'b0;
        if (state_q == LOAD_WAIT && state_d == LOAD_WAIT) begin
            squash_d = squash_q || flush_i;
        end
    end

    always_comb begin
        ld_valid_o  = ld_resp && !squash_q && !flush_i;
        ld_data_o   = '0;
        if (ld_resp && !squash_q && !flush_i) begin
            ld_data_o = mem_data_i;
        end
        st_done_o   = (state_q == STORE_WAIT) && (mem_done_i || timeout);
        bus_error_o = timeout;
    end

    assign mem_load_o    = mem_load_q;
    assign mem_store_o   = mem_store_q;
    assign mem_address_o = mem_address_q;
    assign mem_data_o    = mem_data_q;
    assign mem_width_o   = mem_width_q;

    // A new request on a channel that is still pending or outstanding is a protocol violation.
    assert property (@(posedge clk_i) disable iff (!rst_n_i) !(ld_request_i && ld_busy));
    assert property (@(posedge clk_i) disable iff (!rst_n_i) !(st_request_i && st_busy));
    assert property (@(posedge clk_i) (STARVE_LIMIT > 0) && (TIMEOUT_CYCLES > 0));

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed scenarios plus a random soak,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_memory_port_arbiter;

    localparam int STARVE = 4;
    localparam int TO     = 16;
`ifdef MEM_PORT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        ld_request_i;
    logic [31:0] ld_address_i;
    logic        ld_valid_o;
    logic [31:0] ld_data_o;
    logic        st_request_i;
    logic [31:0] st_address_i;
    logic [31:0] st_data_i;
    logic [1:0]  st_width_i;
    logic        st_buffer_full_i;
    logic        st_done_o;
    logic        mem_load_o;
    logic        mem_store_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_data_o;
    logic [1:0]  mem_width_o;
    logic        mem_valid_i;
    logic [31:0] mem_data_i;
    logic        mem_done_i;
    logic        bus_error_o;

    always #5 clk = ~clk;

    memory_port_arbiter #(
        .STARVE_LIMIT  (STARVE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .flush_i         (flush_i),
        .ld_request_i    (ld_request_i),
        .ld_address_i    (ld_address_i),
        .ld_valid_o      (ld_valid_o),
        .ld_data_o       (ld_data_o),
        .st_request_i    (st_request_i),
        .st_address_i    (st_address_i),
        .st_data_i       (st_data_i),
        .st_width_i      (st_width_i),
        .st_buffer_full_i(st_buffer_full_i),
        .st_done_o       (st_done_o),
        .mem_load_o      (mem_load_o),
        .mem_store_o     (mem_store_o),
        .mem_address_o   (mem_address_o),
        .mem_data_o      (mem_data_o),
        .mem_width_o     (mem_width_o),
        .mem_valid_i     (mem_valid_i),
        .mem_data_i      (mem_data_i),
        .mem_done_i      (mem_done_i),
        .bus_error_o     (bus_error_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: port owner (0 free, 1 load, 2 store), cycles spent owning, pending requests.
    int          m_state, m_age, m_starve;
    bit          m_ld_pend, m_st_pend, m_squash, m_mem_load, m_mem_store;
    logic [31:0] m_ld_addr, m_st_addr, m_st_data, m_addr, m_data;
    logic [1:0]  m_st_width, m_width;

    // Bench-side memory and observation log.
    int          lat;
    bit          rand_lat;
    logic [31:0] rdata;
    string       glog;
    int          ldv_cnt, std_cnt, berr_cnt;
    int          ld_issue_cyc, st_issue_cyc, ldv_cyc, std_cyc, berr_cyc;
    logic [31:0] ldv_data, st_issue_addr, st_issue_data;
    logic [1:0]  st_issue_width;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 0; m_starve = 0;
        m_ld_pend = 0; m_st_pend = 0; m_squash = 0; m_mem_load = 0; m_mem_store = 0;
        m_ld_addr = '0; m_st_addr = '0; m_st_data = '0; m_st_width = '0;
        m_addr = '0; m_data = '0; m_width = '0;
    endtask

    task automatic clear_logs();
        glog = ""; ldv_cnt = 0; std_cnt = 0; berr_cnt = 0;
        ld_issue_cyc = -1; st_issue_cyc = -1; ldv_cyc = -1; std_cyc = -1; berr_cyc = -1;
    endtask

    function automatic bit m_tmo();
        bit resp;
        resp = (m_state == 1 && mem_valid_i) || (m_state == 2 && mem_done_i);
        return TO_EN && (m_state != 0) && !resp && (m_age == TO - 1);
    endfunction

    function automatic bit ld_free();
        return !m_ld_pend && !(m_state == 1 && !mem_valid_i && !m_tmo());
    endfunction

    function automatic bit st_free();
        return !m_st_pend && !(m_state == 2 && !mem_done_i && !m_tmo());
    endfunction

    // Start-of-cycle defaults plus the memory's response for this cycle.
    task automatic prep();
        ld_request_i = 0; st_request_i = 0; flush_i = 0;
        mem_valid_i = 0; mem_done_i = 0; mem_data_i = $urandom;
        if (rand_lat) rdata = $urandom;
        if (rand_lat && m_state != 0 && m_age == 0) lat = $urandom_range(0, 4);
        if (m_state == 1 && m_age == lat) begin
            mem_valid_i = 1; mem_data_i = rdata;
        end
        if (m_state == 2 && m_age == lat) mem_done_i = 1;
    endtask

    task automatic check_cycle();
        bit lv, tmo;
        tmo = m_tmo();
        lv  = (m_state == 1) && mem_valid_i && !m_squash && !flush_i;
        chk("mem_load_o",    mem_load_o,    m_mem_load);
        chk("mem_store_o",   mem_store_o,   m_mem_store);
        chk("mem_address_o", mem_address_o, m_addr);
        chk("mem_data_o",    mem_data_o,    m_data);
        chk("mem_width_o",   mem_width_o,   m_width);
        chk("ld_valid_o",    ld_valid_o,    lv);
        chk("ld_data_o",     ld_data_o,     lv ? mem_data_i : 32'h0);
        chk("st_done_o",     st_done_o,     (m_state == 2) && (mem_done_i || tmo));
        chk("bus_error_o",   bus_error_o,   tmo);
        if (mem_load_o) begin glog = {glog, "L"}; ld_issue_cyc = cyc; end
        if (mem_store_o) begin
            glog = {glog, "S"}; st_issue_cyc = cyc;
            st_issue_addr = mem_address_o; st_issue_data = mem_data_o; st_issue_width = mem_width_o;
        end
        if (ld_valid_o) begin ldv_cnt++; ldv_cyc = cyc; ldv_data = ld_data_o; end
        if (st_done_o) begin std_cnt++; std_cyc = cyc; end
        if (bus_error_o) begin berr_cnt++; berr_cyc = cyc; end
    endtask

    // Advance the model across one clock edge using the rules of the arbiter.
    task automatic model_edge();
        bit resp_ld, resp_st, tmo, ld_busy, st_busy, g_ld, g_st;
        resp_ld = (m_state == 1) && mem_valid_i;
        resp_st = (m_state == 2) && mem_done_i;
        tmo     = m_tmo();
        ld_busy = m_ld_pend || (m_state == 1 && !resp_ld && !tmo);
        st_busy = m_st_pend || (m_state == 2 && !resp_st && !tmo);
        g_ld = 0; g_st = 0;
        if (m_state == 0) begin
            if (m_st_pend && (st_buffer_full_i || m_starve == STARVE)) g_st = 1;
            else if (m_ld_pend && !flush_i) g_ld = 1;
            else if (m_st_pend) g_st = 1;
        end
        m_mem_load = g_ld; m_mem_store = g_st;
        if (g_ld) m_addr = m_ld_addr;
        if (g_st) begin m_addr = m_st_addr; m_data = m_st_data; m_width = m_st_width; end
        if (g_st) m_starve = 0;
        else if (g_ld && m_st_pend && m_starve < STARVE) m_starve++;
        if (m_state == 1 && !resp_ld && !tmo) m_squash = m_squash || flush_i;
        else m_squash = 0;
        if (g_ld) m_ld_pend = 0;
        if (g_st) m_st_pend = 0;
        if (flush_i) m_ld_pend = 0;
        else if (ld_request_i && !ld_busy) begin m_ld_pend = 1; m_ld_addr = ld_address_i; end
        if (st_request_i && !st_busy) begin
            m_st_pend = 1; m_st_addr = st_address_i; m_st_data = st_data_i; m_st_width = st_width_i;
        end
        if (g_ld) begin m_state = 1; m_age = 0; end
        else if (g_st) begin m_state = 2; m_age = 0; end
        else if (m_state != 0 && (resp_ld || resp_st || tmo)) m_state = 0;
        else if (m_state != 0) m_age++;
    endtask

    task automatic tick();
        #1;
        check_cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        prep();
    endtask

    task automatic run_idle(input int budget, input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_state == 0 && !m_ld_pend && !m_st_pend) begin done = 1; break; end
            tick();
        end
        if (m_state == 0 && !m_ld_pend && !m_st_pend) done = 1;
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, left;
        rst_n_i = 0; flush_i = 0; ld_request_i = 0; ld_address_i = '0;
        st_request_i = 0; st_address_i = '0; st_data_i = '0; st_width_i = '0;
        st_buffer_full_i = 0; mem_valid_i = 0; mem_data_i = '0; mem_done_i = 0;
        lat = 1000; rand_lat = 0; rdata = '0;
        model_reset(); clear_logs();

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_load",  mem_load_o,    32'h0);
        chk("rst_mem_store", mem_store_o,   32'h0);
        chk("rst_mem_addr",  mem_address_o, 32'h0);
        chk("rst_mem_data",  mem_data_o,    32'h0);
        chk("rst_ld_valid",  ld_valid_o,    32'h0);
        chk("rst_st_done",   st_done_o,     32'h0);
        chk("rst_bus_error", bus_error_o,   32'h0);
        @(negedge clk);
        rst_n_i = 1;
        prep();

        // Lone load, memory answers three cycles after mem_load_o.
        lat = 3; rdata = 32'hDEADBEEF; clear_logs();
        c0 = cyc; ld_request_i = 1; ld_address_i = 32'h100;
        tick();
        run_idle(30, "t1_idle");
        chk("t1_issue_latency", 32'(ld_issue_cyc - c0), 32'd2);
        chk("t1_resp_latency",  32'(ldv_cyc - ld_issue_cyc), 32'd3);
        chk("t1_ld_data",       ldv_data, 32'hDEADBEEF);
        chk_str("t1_order", glog, "L");

        // Simultaneous load and store, buffer not full: load first.
        lat = 2; rdata = 32'h0BADF00D; clear_logs(); st_buffer_full_i = 0;
        ld_request_i = 1; ld_address_i = 32'h180;
        st_request_i = 1; st_address_i = 32'h200; st_data_i = 32'h11223344; st_width_i = 2'b10;
        tick();
        run_idle(40, "t2_idle");
        chk_str("t2_order", glog, "LS");
        chk("t2_st_addr",  st_issue_addr,  32'h200);
        chk("t2_st_data",  st_issue_data,  32'h11223344);
        chk("t2_st_width", st_issue_width, 32'h2);
        chk("t2_st_done",  32'(std_cnt), 32'd1);
        chk("t2_ld_valid", 32'(ldv_cnt), 32'd1);

        // Same with the store buffer full: store first.
        clear_logs(); st_buffer_full_i = 1;
        ld_request_i = 1; ld_address_i = 32'h184;
        st_request_i = 1; st_address_i = 32'h204; st_data_i = 32'h55667788; st_width_i = 2'b01;
        tick();
        run_idle(40, "t3_idle");
        st_buffer_full_i = 0;
        chk_str("t3_order", glog, "SL");

        // Starvation guard: pending store plus five back-to-back loads.
        lat = 1; clear_logs();
        st_request_i = 1; st_address_i = 32'h300; st_data_i = $urandom; st_width_i = 2'b00;
        ld_request_i = 1; ld_address_i = $urandom;
        left = 4;
        tick();
        for (int i = 0; i < 80; i++) begin
            if (left == 0 && m_state == 0 && !m_ld_pend && !m_st_pend) break;
            if (left > 0 && m_state == 1 && mem_valid_i) begin
                ld_request_i = 1; ld_address_i = $urandom; left--;
            end
            tick();
        end
        chk("t4_loads_sent", 32'(left), 32'd0);
        chk_str("t4_order", glog, "LLLLSL");
        chk("t4_ld_valid", 32'(ldv_cnt), 32'd5);

        // Flush during LOAD_WAIT squashes the returning data.
        lat = 3; rdata = 32'h12345678; clear_logs();
        ld_request_i = 1; ld_address_i = 32'h400;
        tick(); tick(); tick();
        flush_i = 1;
        tick();
        run_idle(30, "t5_idle");
        chk("t5_squashed", 32'(ldv_cnt), 32'd0);
        // Flush together with a request drops the request.
        flush_i = 1; ld_request_i = 1; ld_address_i = 32'h404;
        tick();
        repeat (5) tick();
        chk_str("t5_dropped", glog, "L");
        rdata = 32'hCAFEF00D;
        ld_request_i = 1; ld_address_i = 32'h408;
        tick();
        run_idle(30, "t5b_idle");
        chk("t5_next_valid", 32'(ldv_cnt), 32'd1);
        chk("t5_next_data", ldv_data, 32'hCAFEF00D);

        // Store with no memory answer.
        lat = 1000; clear_logs();
        st_request_i = 1; st_address_i = 32'h500; st_data_i = $urandom; st_width_i = 2'b10;
        tick();
`ifdef MEM_PORT_TIMEOUT_EN
        run_idle(40, "t6_idle");
        chk("t6_timeout_cycle", 32'(berr_cyc - st_issue_cyc), 32'd15);
        chk("t6_done_with_err", 32'(std_cyc), 32'(berr_cyc));
        chk("t6_err_count", 32'(berr_cnt), 32'd1);
`else
        repeat (40) tick();
        chk("t6_no_done", 32'(std_cnt), 32'd0);
        mem_done_i = 1;
        tick();
        run_idle(5, "t6_idle");
        chk("t6_late_done", 32'(std_cnt), 32'd1);
        chk("t6_no_err", 32'(berr_cnt), 32'd0);
`endif

        // Random soak.
        rand_lat = 1; clear_logs();
        for (int i = 0; i < 600; i++) begin
            st_buffer_full_i = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) flush_i = 1;
            if (m_state != 1 && $urandom_range(0, 15) == 0) mem_valid_i = 1;
            if (m_state != 2 && $urandom_range(0, 15) == 0) mem_done_i = 1;
            if (ld_free() && $urandom_range(0, 1) == 0) begin
                ld_request_i = 1; ld_address_i = $urandom;
            end
            if (st_free() && $urandom_range(0, 2) == 0) begin
                st_request_i = 1; st_address_i = $urandom; st_data_i = $urandom;
                st_width_i = 2'($urandom_range(0, 2));
            end
            tick();
        end
        st_buffer_full_i = 0;
        run_idle(100, "soak_drain");

        // Asynchronous reset in the middle of a load.
        rand_lat = 0; lat = 1000; clear_logs();
        ld_request_i = 1; ld_address_i = 32'h600;
        tick(); tick(); tick();
        #2 rst_n_i = 0;
        mem_valid_i = 1; mem_data_i = 32'hFFFF0000;
        #1;
        chk("rst_mid_mem_load", mem_load_o,    32'h0);
        chk("rst_mid_mem_addr", mem_address_o, 32'h0);
        chk("rst_mid_ld_valid", ld_valid_o,    32'h0);
        chk("rst_mid_ld_data",  ld_data_o,     32'h0);
        model_reset();
        @(negedge clk);
        rst_n_i = 1;
        prep();
        clear_logs();
        repeat (4) tick();
        chk_str("rst_mid_no_replay", glog, "");
        lat = 1; rdata = 32'h0F0F0F0F;
        ld_request_i = 1; ld_address_i = 32'h604;
        tick();
        run_idle(20, "rst_mid_idle");
        chk("rst_mid_after_valid", 32'(ldv_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
